atomrvcore_idu: RTL
===================

Name: atomrvcore_idu

Overview:
Instruction-decode stage directly downstream of the instruction-fetch unit. It consumes the registered PC and instruction word from fetch and decodes RV32I fields, immediates and operation class. The result goes to execute through a registered valid/ready pipeline with a one-entry skid buffer, flush support and a retired-decode counter.

Parameters:
- DATAWIDTH, 32, width of PC, instruction, immediate and counter.

Ports:
- clk_i  in  1  core clock, rising edge.
- IDrst_i  in  1  asynchronous active-low reset.
- PC_instr_i  in  DATAWIDTH  PC of the incoming instruction (from fetch PC_instr_o).
- instruction_i  in  DATAWIDTH  incoming instruction word (from fetch instruction_o).
- valid_i  in  1  fetch presents a valid instruction.
- ready_o  out  1  decode can accept; fetch holds PC and instruction while ready_o=0.
- flush_i  in  1  branch/jump redirect; kills all held and incoming instructions.
- ready_i  in  1  execute accepts the current output.
- valid_o  out  1  decoded output valid.
- PC_o  out  DATAWIDTH  PC of the decoded instruction.
- rs1_o, rs2_o, rd_o  out  5 each  register addresses [19:15], [24:20], [11:7].
- funct3_o  out  3  instr[14:12].
- funct7b5_o  out  1  instr[30].
- imm_o  out  DATAWIDTH  sign-extended immediate.
- opclass_o  out  4  0 ILLEGAL, 1 ALU_R, 2 ALU_I, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC, 10 FENCE, 11 SYSTEM.
- RegWE_o  out  1  instruction writes rd.
- illegal_o  out  1  illegal encoding.
- decode_cnt_o  out  DATAWIDTH  count of legal instructions handed to execute.

Behaviour:
- Reset (async, IDrst_i=0): all outputs 0, except ready_o=1. Skid empty, counter 0. Release is synchronous to the next clk_i edge.
- Decode is combinational on the entering word. Decoded fields are registered, giving 1-cycle latency from an accept (valid_i and ready_o) to valid_o.
- States:
  - EMPTY: valid_o=0, ready_o=1.
  - FULL: output register holds an instruction, ready_o=1.
  - SKID: output and skid registers both full, ready_o=0.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + accept + ready_i -> FULL, with the new instruction in the output register.
  - FULL + accept + !ready_i -> SKID, with the new instruction in the skid register.
  - FULL + !accept + ready_i -> EMPTY.
  - SKID + ready_i -> FULL; the skid entry moves to the output register.
  - SKID + !ready_i -> hold.
- ready_o is a register output (= !skid_valid), never combinational from ready_i.
- flush_i=1 -> EMPTY next cycle. Both entries are dropped, and an input accepted in the same cycle is discarded. flush_i has priority over every other event and does not increment the counter.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],0}).
  - U: {[31:12],12'b0}.
  - J: sext({[31],[19:12],[20],[30:21],0}).
  - R, FENCE, SYSTEM: 0.
- Illegal when any of the following holds:
  - instr[1:0]!=2'b11.
  - The opcode is not one of 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17, 0x0F, 0x73.
  - R-type funct7 is not 0x00 or 0x20, or funct7=0x20 with funct3 not in {0,5}.
  - Shift-immediate: funct3=1 with funct7!=0x00, or funct3=5 with funct7 not in {0x00,0x20}.
  - LOAD funct3 in {3,6,7}, STORE funct3>2, BRANCH funct3 in {2,3}, JALR funct3!=0.
- On an illegal instruction: opclass_o=0, illegal_o=1, RegWE_o=0, imm_o=0. The address fields are still passed.
- RegWE_o=1 for ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC when rd!=0; otherwise 0.
- decode_cnt_o increments by 1 on each cycle with valid_o and ready_i and !illegal_o and !flush_i. It wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then valid_i=1 with instruction_i=0xFFF00293 (ADDI x5,x0,-1), PC_instr_i=0x10, ready_i=1 -> next cycle valid_o=1, PC_o=0x10, rd_o=5, rs1_o=0, imm_o=0xFFFFFFFF, opclass_o=2, RegWE_o=1; decode_cnt_o=1 one cycle after the handshake.
- Send 0x0020A423 (SW x2,8(x1)) -> opclass_o=4, rs1_o=1, rs2_o=2, imm_o=0x8, RegWE_o=0. Send 0x123451B7 (LUI x3,0x12345) -> opclass_o=8, imm_o=0x12345000, RegWE_o=1.
- Stall: ready_i=0 with three back-to-back valid inputs at PCs 0x0, 0x4, 0x8 -> 0x0 at the output, 0x4 in skid, ready_o=0 while 0x8 is held. Raise ready_i -> outputs appear in order 0x0, 0x4, 0x8 with no loss or duplication.
- Illegal words: 0x00000000 -> illegal_o=1, opclass_o=0, RegWE_o=0, counter unchanged. 0x40209033 (funct7=0x20, funct3=1) -> illegal_o=1.
- Flush in state SKID with a simultaneous valid input -> next cycle valid_o=0, ready_o=1, counter unchanged. The next accepted instruction appears normally.
- Assert IDrst_i low mid-stall, asynchronously between edges -> valid_o=0, ready_o=1, decode_cnt_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/atomrvcore_idu.sv
// RV32I decode stage: decodes fields, immediate and op class; result registered (1-cycle latency).
// Backpressure via a one-entry skid buffer; ready_o is registered (!skid valid) and flush_i drops everything.
module atomrvcore_idu #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 IDrst_i,
  input  logic [DATAWIDTH-1:0] PC_instr_i,
  input  logic [DATAWIDTH-1:0] instruction_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATAWIDTH-1:0] PC_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [2:0]           funct3_o,
  output logic                 funct7b5_o,
  output logic [DATAWIDTH-1:0] imm_o,
  output logic [3:0]           opclass_o,
  output logic                 RegWE_o,
  output logic                 illegal_o,
  output logic [DATAWIDTH-1:0] decode_cnt_o
);

  localparam logic [3:0] OC_ILLEGAL = 4'd0,  OC_ALU_R = 4'd1, OC_ALU_I = 4'd2, OC_LOAD   = 4'd3,
                         OC_STORE   = 4'd4,  OC_BRANCH = 4'd5, OC_JAL  = 4'd6, OC_JALR   = 4'd7,
                         OC_LUI     = 4'd8,  OC_AUIPC = 4'd9, OC_FENCE = 4'd10, OC_SYSTEM = 4'd11;

  typedef struct packed {
    logic [DATAWIDTH-1:0] pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic [DATAWIDTH-1:0] imm;
    logic [3:0]           opclass;
    logic                 regwe;
    logic                 illegal;
  } dec_t;

  dec_t                 dec_dat;
  dec_t                 out_q, out_d, skid_q, skid_d;
  logic                 out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [DATAWIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;

  logic [31:0]        ins;
  logic [6:0]         opc, f7;
  logic [2:0]         f3;
  logic [3:0]         cls;
  logic               bad;
  logic signed [31:0] imm32;

  assign ins = instruction_i[31:0];
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    cls   = OC_ILLEGAL;
    bad   = 1'b0;
    imm32 = '0;
    case (opc)
      7'h33: begin
        cls = OC_ALU_R;
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      7'h13: begin
        cls   = OC_ALU_I;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        bad   = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      7'h03: begin
        cls   = OC_LOAD;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        bad   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'h23: begin
        cls   = OC_STORE;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bad   = (f3 > 3'd2);
      end
      7'h63: begin
        cls   = OC_BRANCH;
        imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        bad   = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h6F: begin
        cls   = OC_JAL;
        imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: begin
        cls   = OC_JALR;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        bad   = (f3 != 3'd0);
      end
      7'h37: begin cls = OC_LUI;   imm32 = {ins[31:12], 12'b0}; end
      7'h17: begin cls = OC_AUIPC; imm32 = {ins[31:12], 12'b0}; end
      7'h0F: cls = OC_FENCE;
      7'h73: cls = OC_SYSTEM;
      default: bad = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) bad = 1'b1;

    dec_dat          = '0;
    dec_dat.pc       = PC_instr_i;
    dec_dat.rs1      = ins[19:15];
    dec_dat.rs2      = ins[24:20];
    dec_dat.rd       = ins[11:7];
    dec_dat.funct3   = f3;
    dec_dat.funct7b5 = ins[30];
    dec_dat.illegal  = bad;
    if (!bad) begin
      dec_dat.opclass = cls;
      dec_dat.imm     = DATAWIDTH'(imm32);
      dec_dat.regwe   = (ins[11:7] != 5'd0) &&
                        ((cls == OC_ALU_R) || (cls == OC_ALU_I) || (cls == OC_LOAD) ||
                         (cls == OC_JAL) || (cls == OC_JALR) || (cls == OC_LUI) || (cls == OC_AUIPC));
    end
  end

  assign accept = valid_i && ready_o;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (flush_i) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (out_vld_q && ready_i && !out_q.illegal) cnt_d = cnt_q + DATAWIDTH'(1);
      if (skid_vld_q) begin
        if (ready_i) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = 1'b0;
        end
      end else if (!out_vld_q || ready_i) begin
        out_vld_d = accept;
        if (accept) out_d = dec_dat;
      end else if (accept) begin
        // Execute is stalled: park the new word so fetch sees ready_o drop next cycle.
        skid_d     = dec_dat;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge IDrst_i) begin
    if (!IDrst_i) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o      = !skid_vld_q;
  assign valid_o      = out_vld_q;
  assign PC_o         = out_q.pc;
  assign rs1_o        = out_q.rs1;
  assign rs2_o        = out_q.rs2;
  assign rd_o         = out_q.rd;
  assign funct3_o     = out_q.funct3;
  assign funct7b5_o   = out_q.funct7b5;
  assign imm_o        = out_q.imm;
  assign opclass_o    = out_q.opclass;
  assign RegWE_o      = out_q.regwe;
  assign illegal_o    = out_q.illegal;
  assign decode_cnt_o = cnt_q;

endmodule
